// File: rtl/secuenciador_ctrl_pkg.sv
// Shared definitions for the control-unit step sequencer: state encodings and
// default widths, so the decoder and the sequencer agree on the opcode width.
package secuenciador_ctrl_pkg;

   localparam int OP_W_DEF  = 3;
   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      CARGA   = 2'd1,
      EJECUTA = 2'd2,
      FIN     = 2'd3
   } estado_t;

endpackage

// File: rtl/secuenciador_ctrl_contador.sv
// Loadable down-counter for execute cycles; loads max(value,1), stops at 1.
// Latency 1 cycle from load/dec to o_es_uno; no backpressure.
module contador_ciclos
   import secuenciador_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_valor,
   input  logic             i_dec,
   output logic             o_es_uno
);

   logic [CNT_W-1:0] r_cuenta;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cuenta <= '0;
      end else if (i_load) begin
         // A zero count still executes once.
         r_cuenta <= (i_valor == '0) ? CNT_W'(1) : i_valor;
      end else if (i_dec && (r_cuenta > CNT_W'(1))) begin
         r_cuenta <= r_cuenta - CNT_W'(1);
      end
   end

   assign o_es_uno = (r_cuenta == CNT_W'(1));

endmodule

// File: rtl/secuenciador_ctrl.sv
// Step sequencer feeding the 3-to-8 decoder: setup cycle, C enable cycles, fin pulse (C+3 period).
// Accepts via valid/ready only when idle; SEC_CTRL_B2B_EN also accepts in FIN (C+2 period).
module secuenciador_ctrl
   import secuenciador_ctrl_pkg::*;
#(
   parameter int OP_W  = OP_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_instr_valid,
   output logic             o_instr_ready,
   input  logic [OP_W-1:0]  i_instr_op,
   input  logic [CNT_W-1:0] i_instr_ciclos,
   input  logic             i_abortar,
   output logic [OP_W-1:0]  o_dec_ent,
   output logic             o_dec_ena,
   output logic             o_ocupado,
   output logic             o_fin
);

   estado_t         r_estado;
   logic [OP_W-1:0] r_dec_ent;
   logic            r_dec_ena;
   logic            r_fin;

   logic w_listo;
   logic w_hs;
   logic w_es_uno;
   logic w_dec;

`ifdef SEC_CTRL_B2B_EN
   assign w_listo = (r_estado == ESPERA) || (r_estado == FIN);
`else
   assign w_listo = (r_estado == ESPERA);
`endif

   // Decoded from state, but held low while reset is asserted.
   assign o_instr_ready = ~i_rst & w_listo;
   assign o_ocupado     = ~i_rst & (r_estado != ESPERA);
   assign w_hs          = i_instr_valid & o_instr_ready;
   assign w_dec         = (r_estado == EJECUTA) & ~i_abortar;

   contador_ciclos #(
      .CNT_W (CNT_W)
   ) u_contador (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_load   (w_hs),
      .i_valor  (i_instr_ciclos),
      .i_dec    (w_dec),
      .o_es_uno (w_es_uno)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_estado  <= ESPERA;
         r_dec_ent <= '0;
         r_dec_ena <= 1'b0;
         r_fin     <= 1'b0;
      end else begin
         r_dec_ena <= 1'b0;
         r_fin     <= 1'b0;
         case (r_estado)
            ESPERA: begin
               if (w_hs) begin
                  r_dec_ent <= i_instr_op;
                  r_estado  <= CARGA;
               end
            end
            CARGA: begin
               if (i_abortar) begin
                  r_estado <= ESPERA;
               end else begin
                  r_estado  <= EJECUTA;
                  r_dec_ena <= 1'b1;
               end
            end
            EJECUTA: begin
               // Abort beats the last execute cycle: no fin in that case.
               if (i_abortar) begin
                  r_estado <= ESPERA;
               end else if (w_es_uno) begin
                  r_estado <= FIN;
                  r_fin    <= 1'b1;
               end else begin
                  r_dec_ena <= 1'b1;
               end
            end
            FIN: begin
               if (w_hs) begin
                  r_dec_ent <= i_instr_op;
                  r_estado  <= CARGA;
               end else begin
                  r_estado <= ESPERA;
               end
            end
         endcase
      end
   end

   assign o_dec_ent = r_dec_ent;
   assign o_dec_ena = r_dec_ena;
   assign o_fin     = r_fin;

endmodule

// File: tb/tb_secuenciador_ctrl.sv
// Directed bench for secuenciador_ctrl: reset, latency, zero count, abort,
// back-to-back (both macro settings) and mid-operation reset.
module tb_secuenciador_ctrl;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [2:0] instr_op;
   logic [3:0] instr_ciclos;
   logic       abortar;
   logic [2:0] dec_ent;
   logic       dec_ena;
   logic       ocupado;
   logic       fin;

   int n_chk = 0;
   int n_err = 0;

`ifdef SEC_CTRL_B2B_EN
   localparam logic B2B = 1'b1;
`else
   localparam logic B2B = 1'b0;
`endif

   secuenciador_ctrl dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_instr_valid  (instr_valid),
      .o_instr_ready  (instr_ready),
      .i_instr_op     (instr_op),
      .i_instr_ciclos (instr_ciclos),
      .i_abortar      (abortar),
      .o_dec_ent      (dec_ent),
      .o_dec_ena      (dec_ena),
      .o_ocupado      (ocupado),
      .o_fin          (fin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      n_chk++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   // Advance one clock; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_outs(input string tag, input logic rdy, input logic ocu,
                           input logic [2:0] ent, input logic ena, input logic f);
      chk({tag, ".ready"},   {7'd0, instr_ready}, {7'd0, rdy});
      chk({tag, ".ocupado"}, {7'd0, ocupado},     {7'd0, ocu});
      chk({tag, ".dec_ent"}, {5'd0, dec_ent},     {5'd0, ent});
      chk({tag, ".dec_ena"}, {7'd0, dec_ena},     {7'd0, ena});
      chk({tag, ".fin"},     {7'd0, fin},         {7'd0, f});
   endtask

   // Handshake, then check CARGA, C enable cycles, FIN and the return to idle.
   task automatic run_instr(input string tag, input logic [2:0] op, input logic [3:0] c);
      int n;
      n = (c == 0) ? 1 : int'(c);
      instr_valid  = 1'b1;
      instr_op     = op;
      instr_ciclos = c;
      tick();
      instr_valid  = 1'b0;
      instr_op     = ~op;
      instr_ciclos = 4'd9;
      chk_outs({tag, ".carga"}, 1'b0, 1'b1, op, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) begin
         tick();
         chk_outs({tag, ".ejecuta"}, 1'b0, 1'b1, op, 1'b1, 1'b0);
      end
      tick();
      chk_outs({tag, ".fin"}, B2B, 1'b1, op, 1'b0, 1'b1);
      tick();
      chk_outs({tag, ".espera"}, 1'b1, 1'b0, op, 1'b0, 1'b0);
   endtask

   initial begin
      rst          = 1'b1;
      instr_valid  = 1'b1;
      instr_op     = 3'd7;
      instr_ciclos = 4'd4;
      abortar      = 1'b0;

      // Reset held two edges with valid asserted: nothing is accepted.
      tick();
      tick();
      chk_outs("reset", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      rst         = 1'b0;
      instr_valid = 1'b0;
      #1;
      chk("reset.ready_after", {7'd0, instr_ready}, 8'd1);
      tick();
      chk_outs("idle", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

      run_instr("single", 3'b101, 4'd3);
      run_instr("zero", 3'b010, 4'd0);

      // Abort in the 2nd execute cycle.
      instr_valid = 1'b1; instr_op = 3'd4; instr_ciclos = 4'd5;
      tick();
      instr_valid = 1'b0;
      tick();
      chk_outs("abort.ej1", 1'b0, 1'b1, 3'd4, 1'b1, 1'b0);
      tick();
      abortar = 1'b1;
      tick();
      abortar = 1'b0;
      chk_outs("abort.after", 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);
      tick();
      chk_outs("abort.idle", 1'b1, 1'b0, 3'd4, 1'b0, 1'b0);

      // Abort coinciding with the last execute cycle.
      instr_valid = 1'b1; instr_op = 3'd3; instr_ciclos = 4'd2;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      chk_outs("abort_last.ej2", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
      abortar = 1'b1;
      tick();
      abortar = 1'b0;
      chk_outs("abort_last.after", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);
      tick();
      chk_outs("abort_last.idle", 1'b1, 1'b0, 3'd3, 1'b0, 1'b0);

      // Back-to-back with valid held: op=1/2 cycles then op=6/1 cycle.
      instr_valid = 1'b1; instr_op = 3'd1; instr_ciclos = 4'd2;
      tick();
      instr_op = 3'd6; instr_ciclos = 4'd1;
      chk_outs("b2b.carga1", 1'b0, 1'b1, 3'd1, 1'b0, 1'b0);
      tick();
      tick();
      chk_outs("b2b.ej1", 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
      tick();
      chk_outs("b2b.fin1", B2B, 1'b1, 3'd1, 1'b0, 1'b1);
      tick();
      if (B2B) begin
         instr_valid = 1'b0;
         chk_outs("b2b.carga2", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      end else begin
         chk_outs("b2b.gap", 1'b1, 1'b0, 3'd1, 1'b0, 1'b0);
         tick();
         instr_valid = 1'b0;
         chk_outs("b2b.carga2", 1'b0, 1'b1, 3'd6, 1'b0, 1'b0);
      end
      tick();
      chk_outs("b2b.ej2", 1'b0, 1'b1, 3'd6, 1'b1, 1'b0);
      tick();
      chk_outs("b2b.fin2", B2B, 1'b1, 3'd6, 1'b0, 1'b1);
      tick();
      chk_outs("b2b.idle", 1'b1, 1'b0, 3'd6, 1'b0, 1'b0);

      // Reset on the 3rd enable cycle of a 7-cycle instruction.
      instr_valid = 1'b1; instr_op = 3'd3; instr_ciclos = 4'd7;
      tick();
      instr_valid = 1'b0;
      tick();
      tick();
      tick();
      chk_outs("rst_mid.ej3", 1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_outs("rst_mid.in_rst", 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_outs("rst_mid.idle", 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      run_instr("after_rst", 3'd7, 4'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
